// File: rtl/hist_bin_reader_if.sv
// Sample-in / histogram-out bus for hist_bin_reader.
// The master side issues control pulses and sample groups and consumes readout words;
// the slave side is the accumulator.
interface hist_bin_reader_if #(
  parameter int NBINS = 8,
  parameter int CW    = 16
);
  localparam int BW = $clog2(NBINS);

  logic          start;
  logic          stop;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    o1;
  logic [7:0]    o2;
  logic [7:0]    o3;
  logic [7:0]    o4;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_bin;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic          busy;

  modport master (
    output start, stop, in_valid, o1, o2, o3, o4, out_ready,
    input  in_ready, out_valid, out_bin, out_count, out_last, busy
  );

  modport slave (
    input  start, stop, in_valid, o1, o2, o3, o4, out_ready,
    output in_ready, out_valid, out_bin, out_count, out_last, busy
  );
endinterface

// File: rtl/hist_bin_reader.sv
// Sequential histogram accumulator and reader.
// Groups of four 8-bit samples are binned into NBINS equal-width bins with saturating
// per-bin counters. After stop, the histogram is streamed out one bin per handshake.
// NBINS must be a power of two in 2..256 and CW at least 3.
module hist_bin_reader #(
  parameter int NBINS = 8,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  hist_bin_reader_if.slave bus
);
  localparam int BW = $clog2(NBINS);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt      [NBINS];
  logic [CW-1:0] cnt_next [NBINS];
  logic [BW-1:0] samp_bin [4];
  logic [BW-1:0] next_bin;
  logic          accept;

  // The bin index of a sample is its top BW bits.
  assign samp_bin[0] = bus.o1[7 -: BW];
  assign samp_bin[1] = bus.o2[7 -: BW];
  assign samp_bin[2] = bus.o3[7 -: BW];
  assign samp_bin[3] = bus.o4[7 -: BW];

  // in_ready is only high in ACCUM, so this is the accepted-beat condition.
  assign accept   = bus.in_valid & bus.in_ready;
  assign next_bin = bus.out_bin + BW'(1);

  // Next value of every counter: add how many of the four samples hit the bin, saturating.
  always_comb begin
    logic [2:0]  k;
    logic [CW:0] sum;
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    k   = '0;
    sum = '0;
    for (int b = 0; b < NBINS; b++) begin
      k = '0;
      for (int s = 0; s < 4; s++) begin
        if (samp_bin[s] == BW'(b)) k = k + 3'd1;
      end
      sum         = {1'b0, cnt[b]} + {{(CW-2){1'b0}}, k};
      cnt_next[b] = cnt[b];
      if (accept) cnt_next[b] = sum[CW] ? '1 : sum[CW-1:0];
    end
  end

  // Control FSM, counter storage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: reset must zero the counters, so the counter array sits in the reset branch
      // even though storage arrays are normally left out of it.
      // NOTE: all sequential state uses non-blocking assignments.
      state         <= IDLE;
      for (int b = 0; b < NBINS; b++) cnt[b] <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_bin   <= '0;
      bus.out_count <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= CLEAR;
            bus.busy <= 1'b1;
          end
        end
        CLEAR: begin
          for (int b = 0; b < NBINS; b++) cnt[b] <= '0;
          state        <= ACCUM;
          bus.in_ready <= 1'b1;
        end
        ACCUM: begin
          for (int b = 0; b < NBINS; b++) cnt[b] <= cnt_next[b];
          if (bus.stop) begin
            // A beat accepted in the stop cycle must already be visible in the first word.
            state         <= DRAIN;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_bin   <= '0;
            bus.out_count <= cnt_next[0];
            bus.out_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (bus.out_last) begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_bin   <= '0;
              bus.out_count <= '0;
              bus.busy      <= 1'b0;
            end else begin
              bus.out_bin   <= next_bin;
              bus.out_count <= cnt[next_bin];
              bus.out_last  <= (next_bin == BW'(NBINS - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hist_bin_reader.sv
// Testbench for hist_bin_reader: a 16-bit-counter instance and a 4-bit-counter instance
// see the same stimulus; expected histograms are pushed into queues and a negedge
// monitor pops and compares each handshaken readout word.
module tb_hist_bin_reader;
  localparam int NBINS = 8;
  localparam int CW    = 16;
  localparam int SCW   = 4;

  typedef struct packed {
    logic [2:0]  bin;
    logic [15:0] count;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hist_bin_reader_if #(.NBINS(NBINS), .CW(CW))  bus ();
  hist_bin_reader_if #(.NBINS(NBINS), .CW(SCW)) sbus ();

  hist_bin_reader #(.NBINS(NBINS), .CW(CW))  dut     (.clk(clk), .reset(reset), .bus(bus.slave));
  hist_bin_reader #(.NBINS(NBINS), .CW(SCW)) dut_sat (.clk(clk), .reset(reset), .bus(sbus.slave));

  // The saturating instance mirrors every input of the main one.
  assign sbus.start     = bus.start;
  assign sbus.stop      = bus.stop;
  assign sbus.in_valid  = bus.in_valid;
  assign sbus.o1        = bus.o1;
  assign sbus.o2        = bus.o2;
  assign sbus.o3        = bus.o3;
  assign sbus.o4        = bus.o4;
  assign sbus.out_ready = bus.out_ready;

  int    tests_run    = 0;
  int    tests_failed = 0;
  word_t exp_q[$];
  word_t sexp_q[$];
  int    hist [NBINS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hist();
    word_t w;
    for (int b = 0; b < NBINS; b++) begin
      w.bin   = 3'(b);
      w.last  = (b == NBINS - 1);
      w.count = 16'(hist[b]);
      exp_q.push_back(w);
      w.count = (hist[b] > 15) ? 16'd15 : 16'(hist[b]);
      sexp_q.push_back(w);
    end
  endtask

  // Scoreboard monitor: compare on handshake, check stability after a stalled cycle.
  word_t held, sheld;
  logic  hold_v = 1'b0, shold_v = 1'b0;
  always @(negedge clk) begin
    word_t e;
    if (reset) begin
      hold_v  = 1'b0;
      shold_v = 1'b0;
    end else begin
      if (hold_v && bus.out_valid) begin
        check("hold out_bin", bus.out_bin, held.bin);
        check("hold out_count", bus.out_count, held.count);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected word: got bin %0d, expected none", bus.out_bin);
        end else begin
          e = exp_q.pop_front();
          check("out_bin", bus.out_bin, e.bin);
          check("out_count", bus.out_count, e.count);
          check("out_last", bus.out_last, e.last);
        end
        hold_v = 1'b0;
      end else if (bus.out_valid) begin
        held.bin   = bus.out_bin;
        held.count = bus.out_count;
        held.last  = bus.out_last;
        hold_v     = 1'b1;
      end else begin
        hold_v = 1'b0;
      end

      if (shold_v && sbus.out_valid) begin
        check("sat hold out_bin", sbus.out_bin, sheld.bin);
        check("sat hold out_count", sbus.out_count, sheld.count);
      end
      if (sbus.out_valid && sbus.out_ready) begin
        if (sexp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL sat unexpected word: got bin %0d, expected none", sbus.out_bin);
        end else begin
          e = sexp_q.pop_front();
          check("sat out_bin", sbus.out_bin, e.bin);
          check("sat out_count", sbus.out_count, e.count);
          check("sat out_last", sbus.out_last, e.last);
        end
        shold_v = 1'b0;
      end else if (sbus.out_valid) begin
        sheld.bin   = sbus.out_bin;
        sheld.count = 16'(sbus.out_count);
        sheld.last  = sbus.out_last;
        shold_v     = 1'b1;
      end else begin
        shold_v = 1'b0;
      end
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("in_ready low in CLEAR", bus.in_ready, 0);
    check("busy after start", bus.busy, 1);
    cyc();
    check("in_ready in ACCUM", bus.in_ready, 1);
  endtask

  task automatic beat(input logic [7:0] a, b, c, d, input logic with_stop);
    bus.in_valid = 1'b1;
    bus.o1 = a; bus.o2 = b; bus.o3 = c; bus.o4 = d;
    bus.stop = with_stop;
    cyc();
    bus.in_valid = 1'b0;
    bus.stop     = 1'b0;
    if (with_stop) begin
      check("out_valid after stop+beat", bus.out_valid, 1);
      check("in_ready after stop+beat", bus.in_ready, 0);
    end
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check("out_valid after stop", bus.out_valid, 1);
    check("first out_bin", bus.out_bin, 0);
  endtask

  // Drive out_ready from a 5-cycle pattern until the block returns to IDLE.
  task automatic drain(input logic [4:0] pat, input logic start_during);
    logic done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus.out_ready = pat[i % 5];
      bus.start     = start_during && (i == 1);
      cyc();
      bus.start = 1'b0;
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    bus.out_ready = 1'b0;
    check("drain finished", done, 1);
    check("out_valid low after drain", bus.out_valid, 0);
    check("words left", exp_q.size(), 0);
    check("sat words left", sexp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.o1 = '0; bus.o2 = '0; bus.o3 = '0; bus.o4 = '0;
    #12;
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_last", bus.out_last, 0);
    check("reset out_bin", bus.out_bin, 0);
    check("reset out_count", bus.out_count, 0);
    check("reset busy", bus.busy, 0);
    reset = 1'b0;
    cyc();

    // stop while idle is ignored
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check("stop in IDLE busy", bus.busy, 0);
    check("stop in IDLE out_valid", bus.out_valid, 0);

    // basic binning
    do_start();
    beat(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    hist = '{4, 0, 0, 0, 0, 0, 0, 0};
    push_hist();
    do_stop();
    drain(5'b11111, 1'b0);

    // spread across bins
    do_start();
    beat(8'd31, 8'd32, 8'd255, 8'd224, 1'b0);
    beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    hist = '{5, 1, 0, 0, 0, 0, 0, 2};
    push_hist();
    do_stop();
    drain(5'b11111, 1'b0);

    // saturation: 20 samples in bin0 (4-bit instance holds at 15)
    do_start();
    repeat (5) beat(8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
    hist = '{20, 0, 0, 0, 0, 0, 0, 0};
    push_hist();
    do_stop();
    drain(5'b11111, 1'b0);

    // back-pressure with distinct counts per bin, out_ready 0,0,1,0,1
    do_start();
    beat(8'd0, 8'd40, 8'd40, 8'd70, 1'b0);
    beat(8'd70, 8'd70, 8'd100, 8'd100, 1'b0);
    beat(8'd100, 8'd100, 8'd130, 8'd200, 1'b0);
    hist = '{1, 2, 3, 4, 1, 0, 1, 0};
    push_hist();
    do_stop();
    drain(5'b10100, 1'b0);

    // start ignored in ACCUM and DRAIN, stop together with a beat
    do_start();
    beat(8'd64, 8'd64, 8'd64, 8'd64, 1'b0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("start in ACCUM in_ready", bus.in_ready, 1);
    beat(8'd64, 8'd64, 8'd64, 8'd64, 1'b1);
    hist = '{0, 0, 8, 0, 0, 0, 0, 0};
    push_hist();
    drain(5'b10100, 1'b1);
    repeat (3) cyc();
    check("start in DRAIN ignored busy", bus.busy, 0);

    // a fresh start clears every bin
    do_start();
    do_stop();
    hist = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_hist();
    drain(5'b11111, 1'b0);

    // asynchronous reset while bin3 is presented
    do_start();
    beat(8'd0, 8'd32, 8'd64, 8'd96, 1'b0);
    beat(8'd128, 8'd160, 8'd192, 8'd224, 1'b0);
    hist = '{1, 1, 1, 1, 1, 1, 1, 1};
    push_hist();
    do_stop();
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid && bus.out_bin == 3'd3) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    bus.out_ready = 1'b0;
    check("reached bin3", found, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset out_valid", bus.out_valid, 0);
    check("async reset busy", bus.busy, 0);
    check("async reset out_bin", bus.out_bin, 0);
    check("async reset sat out_valid", sbus.out_valid, 0);
    check("words popped before reset", exp_q.size(), 5);
    exp_q.delete();
    sexp_q.delete();
    #7 reset = 1'b0;
    cyc();
    do_start();
    do_stop();
    hist = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_hist();
    drain(5'b11111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
